// File: rtl/espi_target_responder_pkg.sv
// rtl/espi_target_responder_pkg.sv - shared encodings for the eSPI target responder
package espi_target_responder_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CMD   = 3'd1;
    localparam logic [2:0] ST_WDATA = 3'd2;
    localparam logic [2:0] ST_TAR   = 3'd3;
    localparam logic [2:0] ST_RDATA = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;
    localparam logic [2:0] ST_HOLD  = 3'd6;

    localparam logic [1:0] CMD_READ     = 2'b01;
    localparam logic [1:0] CMD_WRITE    = 2'b10;
    localparam logic [7:0] ACK_CODE_DEF = 8'h0F;
    localparam int         ADDR_MSB     = 3;
    localparam int         ADDR_LSB     = 2;

    typedef enum logic [1:0] {
        OP_ILLEGAL = 2'd0,
        OP_READ    = 2'd1,
        OP_WRITE   = 2'd2
    } cmd_op_e;

    function automatic cmd_op_e decode_cmd(input logic [1:0] op_bits);
        if (op_bits == CMD_READ)
            return OP_READ;
        else if (op_bits == CMD_WRITE)
            return OP_WRITE;
        else
            return OP_ILLEGAL;
    endfunction

endpackage

// File: rtl/espi_target_responder_if.sv
// rtl/espi_target_responder_if.sv - single-IO eSPI link between master and target
interface espi_target_responder_if;
    logic sclk;
    logic cs_n;
    logic io0_in;
    logic io0_out;
    logic io0_oe;

    modport master (
        output sclk,
        output cs_n,
        output io0_in,
        input  io0_out,
        input  io0_oe
    );

    modport slave (
        input  sclk,
        input  cs_n,
        input  io0_in,
        output io0_out,
        output io0_oe
    );
endinterface

// File: rtl/espi_target_responder_sync_edge.sv
// rtl/espi_target_responder_sync_edge.sv - multi-stage synchroniser with rise/fall pulses
module espi_target_responder_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync <= {STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_rise = r_sync[STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/espi_target_responder.sv
// rtl/espi_target_responder.sv - eSPI single-IO target with a small read/write register bank
module espi_target_responder
    import espi_target_responder_pkg::*;
#(
    parameter int         NUM_REGS    = 4,
    parameter int         TAR_CYCLES  = 2,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] ACK_CODE    = ACK_CODE_DEF,
    parameter logic [7:0] REG_RST_VAL = 8'h00
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    espi_target_responder_if.slave  link,
    input  logic [1:0]              i_reg_rd_addr,
    output logic [7:0]              o_reg_rd_data,
    output logic                    o_xfer_done,
    output logic                    o_err_illegal,
    output logic                    o_busy
);

    localparam logic [2:0] TAR_LAST = 3'(TAR_CYCLES);

    logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;
    logic w_io0_s;
    logic [7:0] w_rx_byte;
    logic [1:0] w_rx_addr;
    cmd_op_e    w_op;
    logic       w_last_bit;

    logic [SYNC_STAGES-1:0] r_io0_sync;
    logic [2:0] r_state;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_tx;
    logic [1:0] r_addr;
    logic       r_io0_out;
    logic       r_io0_oe;
    logic       r_xfer_done;
    logic       r_err_illegal;
    logic [7:0] r_regs [4];

    espi_target_responder_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_d       (link.sclk),
        .o_rise    (w_sclk_rise),
        .o_fall    (w_sclk_fall)
    );

    espi_target_responder_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_d       (link.cs_n),
        .o_rise    (w_cs_rise),
        .o_fall    (w_cs_fall)
    );

    // io0 goes through the same depth as sclk so the sample on a rise pulse lines up
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            r_io0_sync <= '0;
        else
            r_io0_sync <= {r_io0_sync[SYNC_STAGES-2:0], link.io0_in};
    end

    assign w_io0_s    = r_io0_sync[SYNC_STAGES-1];
    assign w_rx_byte  = {r_shift[6:0], w_io0_s};
    assign w_rx_addr  = w_rx_byte[ADDR_MSB:ADDR_LSB];
    assign w_op       = decode_cmd(w_rx_byte[1:0]);
    assign w_last_bit = (r_bit_cnt == 3'd7);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= ST_IDLE;
            r_bit_cnt     <= 3'd0;
            r_shift       <= 8'h00;
            r_tx          <= 8'h00;
            r_addr        <= 2'd0;
            r_io0_out     <= 1'b0;
            r_io0_oe      <= 1'b0;
            r_xfer_done   <= 1'b0;
            r_err_illegal <= 1'b0;
            for (int i = 0; i < 4; i++)
                r_regs[i] <= REG_RST_VAL;
        end else begin
            r_xfer_done   <= 1'b0;
            r_err_illegal <= 1'b0;
            // Chip-select release aborts anything in flight; only DONE counts as completion
            if (r_state != ST_IDLE && w_cs_rise) begin
                r_io0_oe  <= 1'b0;
                r_io0_out <= 1'b0;
                r_state   <= ST_IDLE;
                if (r_state == ST_DONE)
                    r_xfer_done <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_cs_fall) begin
                            r_state   <= ST_CMD;
                            r_bit_cnt <= 3'd0;
                        end
                    end
                    ST_CMD: begin
                        if (w_sclk_rise) begin
                            r_shift   <= w_rx_byte;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (w_last_bit) begin
                                r_addr <= w_rx_addr;
                                case (w_op)
                                    OP_READ: begin
                                        r_tx    <= r_regs[w_rx_addr];
                                        r_state <= ST_TAR;
                                    end
                                    OP_WRITE: r_state <= ST_WDATA;
                                    default: begin
                                        r_err_illegal <= 1'b1;
                                        r_state       <= ST_HOLD;
                                    end
                                endcase
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (w_sclk_rise) begin
                            r_shift   <= w_rx_byte;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (w_last_bit) begin
                                if ({1'b0, r_addr} < 3'(NUM_REGS))
                                    r_regs[r_addr] <= w_rx_byte;
                                r_tx    <= ACK_CODE;
                                r_state <= ST_TAR;
                            end
                        end
                    end
                    // The first fall here closes the last received bit; TAR periods run fall to fall
                    ST_TAR: begin
                        if (w_sclk_fall) begin
                            if (r_bit_cnt == TAR_LAST) begin
                                r_io0_oe  <= 1'b1;
                                r_io0_out <= r_tx[7];
                                r_tx      <= {r_tx[6:0], 1'b0};
                                r_bit_cnt <= 3'd0;
                                r_state   <= ST_RDATA;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (w_sclk_fall) begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (w_last_bit) begin
                                r_io0_oe  <= 1'b0;
                                r_io0_out <= 1'b0;
                                r_state   <= ST_DONE;
                            end else begin
                                r_io0_out <= r_tx[7];
                                r_tx      <= {r_tx[6:0], 1'b0};
                            end
                        end
                    end
                    ST_DONE, ST_HOLD: ;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign link.io0_out  = r_io0_out;
    assign link.io0_oe   = r_io0_oe;
    assign o_xfer_done   = r_xfer_done;
    assign o_err_illegal = r_err_illegal;
    assign o_busy        = (r_state != ST_IDLE);
    assign o_reg_rd_data = ({1'b0, i_reg_rd_addr} < 3'(NUM_REGS)) ? r_regs[i_reg_rd_addr] : 8'h00;

endmodule

// File: tb/tb_espi_target_responder.sv
// tb/tb_espi_target_responder.sv - self-checking bench for espi_target_responder
module tb_espi_target_responder;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] rd_addr = 2'd0;
    logic [7:0] rd_data;
    logic       xfer_done, err_illegal, busy;

    int checks = 0;
    int failures = 0;
    int n_xfer = 0;
    int n_err = 0;
    int n_oe_clk = 0;

    logic [7:0] m_regs [4];

    espi_target_responder_if u_if ();

    espi_target_responder dut (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .link          (u_if.slave),
        .i_reg_rd_addr (rd_addr),
        .o_reg_rd_data (rd_data),
        .o_xfer_done   (xfer_done),
        .o_err_illegal (err_illegal),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (xfer_done === 1'b1)     n_xfer   <= n_xfer + 1;
        if (err_illegal === 1'b1)   n_err    <= n_err + 1;
        if (u_if.io0_oe === 1'b1)   n_oe_clk <= n_oe_clk + 1;
    end

    // Master side of the link: drive on sclk low, sample the target on each rise
    task automatic run_frame(input logic [7:0] cmd, input logic [7:0] wdata, input int n_rises,
                             input bit end_cs, input int gap, output logic [7:0] rx, output int oe_rises);
        bit is_write;
        is_write = (cmd[1:0] == 2'b10);
        rx = 8'h00;
        oe_rises = 0;
        u_if.cs_n = 1'b0;
        #80;
        for (int i = 0; i < n_rises; i++) begin
            if (i < 8)
                u_if.io0_in = cmd[7-i];
            else if (i < 16 && is_write)
                u_if.io0_in = wdata[15-i];
            else
                u_if.io0_in = 1'b0;
            #40 u_if.sclk = 1'b1;
            if (u_if.io0_oe === 1'b1) begin
                oe_rises++;
                rx = {rx[6:0], u_if.io0_out};
            end
            #40 u_if.sclk = 1'b0;
        end
        u_if.io0_in = 1'b0;
        if (end_cs) begin
            #40 u_if.cs_n = 1'b1;
            #(gap);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        checks++; if (u_if.io0_oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", u_if.io0_oe); end
        checks++; if (u_if.io0_out !== 1'b0) begin failures++; $display("FAIL reset_out got=%b exp=0", u_if.io0_out); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (xfer_done !== 1'b0 || err_illegal !== 1'b0) begin
            failures++; $display("FAIL reset_pulses got=%b%b exp=00", xfer_done, err_illegal); end
        for (int a = 0; a < 4; a++) begin
            rd_addr = 2'(a);
            #1;
            checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL reset_reg%0d got=%h exp=00", a, rd_data); end
            m_regs[a] = 8'h00;
        end
        #20 reset_n = 1'b1;
        @(negedge clk); #2;
    endtask

    task automatic do_txn(input string name, input logic [7:0] cmd, input logic [7:0] wdata, input int gap);
        logic [7:0] rx, exp_rx;
        int oe_rises, x0, e0, o0, n_rises, exp_oe;
        bit legal;
        logic [1:0] a;
        a = cmd[3:2];
        legal = (cmd[1:0] == 2'b01) || (cmd[1:0] == 2'b10);
        n_rises = (cmd[1:0] == 2'b10) ? 26 : 18;
        exp_rx = (cmd[1:0] == 2'b10) ? 8'h0F : m_regs[a];
        exp_oe = legal ? 8 : 0;
        x0 = n_xfer; e0 = n_err; o0 = n_oe_clk;
        run_frame(cmd, wdata, n_rises, 1'b1, gap, rx, oe_rises);
        if (cmd[1:0] == 2'b10) m_regs[a] = wdata;
        checks++; if (oe_rises !== exp_oe) begin failures++; $display("FAIL %s_oe_bits got=%0d exp=%0d", name, oe_rises, exp_oe); end
        if (legal) begin
            checks++; if (rx !== exp_rx) begin failures++; $display("FAIL %s_rx got=%h exp=%h", name, rx, exp_rx); end
        end else begin
            checks++; if (n_oe_clk != o0) begin failures++; $display("FAIL %s_oe_quiet got=%0d exp=0", name, n_oe_clk - o0); end
        end
        checks++; if (n_xfer - x0 != (legal ? 1 : 0)) begin
            failures++; $display("FAIL %s_xfer_done got=%0d exp=%0d", name, n_xfer - x0, legal ? 1 : 0); end
        checks++; if (n_err - e0 != (legal ? 0 : 1)) begin
            failures++; $display("FAIL %s_err_illegal got=%0d exp=%0d", name, n_err - e0, legal ? 0 : 1); end
        rd_addr = a;
        #1;
        checks++; if (rd_data !== m_regs[a]) begin failures++; $display("FAIL %s_peek got=%h exp=%h", name, rd_data, m_regs[a]); end
        @(negedge clk); #2;
    endtask

    task automatic test_read_after_reset();
        do_txn("read0", 8'h01, 8'h00, 120);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL read0_busy got=%b exp=0", busy); end
    endtask

    task automatic test_write_then_read();
        do_txn("write1", 8'h06, 8'hAA, 120);
        do_txn("read1", 8'h05, 8'h00, 120);
    endtask

    task automatic test_illegal();
        do_txn("illegal", 8'h03, 8'h00, 120);
    endtask

    task automatic test_abort_write();
        logic [7:0] rx;
        int oe_rises, x0;
        x0 = n_xfer;
        run_frame(8'h0A, 8'hFF, 13, 1'b1, 120, rx, oe_rises);
        rd_addr = 2'd2;
        #1;
        checks++; if (rd_data !== m_regs[2]) begin failures++; $display("FAIL abort_reg got=%h exp=%h", rd_data, m_regs[2]); end
        checks++; if (busy !== 1'b0 || u_if.io0_oe !== 1'b0) begin
            failures++; $display("FAIL abort_idle got busy=%b oe=%b exp=0/0", busy, u_if.io0_oe); end
        checks++; if (n_xfer != x0 || oe_rises != 0) begin
            failures++; $display("FAIL abort_quiet got xfer=%0d oe=%0d exp=0/0", n_xfer - x0, oe_rises); end
        @(negedge clk); #2;
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] rx;
        int oe_rises;
        do_txn("prewrite", 8'h06, 8'hC3, 120);
        run_frame(8'h05, 8'h00, 14, 1'b0, 0, rx, oe_rises);
        #40;
        checks++; if (u_if.io0_oe !== 1'b1 || busy !== 1'b1) begin
            failures++; $display("FAIL midread_active got oe=%b busy=%b exp=1/1", u_if.io0_oe, busy); end
        checks++; if (rx[3:0] !== 4'hC) begin failures++; $display("FAIL midread_bits got=%h exp=c", rx[3:0]); end
        reset_n = 1'b0;
        #1;
        checks++; if (u_if.io0_oe !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL midread_reset got oe=%b busy=%b exp=0/0", u_if.io0_oe, busy); end
        for (int a = 0; a < 4; a++) begin
            rd_addr = 2'(a);
            #1;
            checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL midread_reg%0d got=%h exp=00", a, rd_data); end
            m_regs[a] = 8'h00;
        end
        u_if.cs_n = 1'b1;
        #100 reset_n = 1'b1;
        @(negedge clk); #2;
    endtask

    task automatic test_back_to_back();
        do_txn("b2b_write", 8'h0E, 8'h5A, 80);
        do_txn("b2b_read", 8'h0D, 8'h00, 80);
        #100;
        @(negedge clk); #2;
    endtask

    task automatic test_random();
        logic [7:0] cmd, d;
        for (int k = 0; k < 20; k++) begin
            cmd = 8'($urandom);
            d   = 8'($urandom);
            do_txn("rand", cmd, d, 120);
        end
    endtask

    initial begin
        u_if.sclk   = 1'b0;
        u_if.cs_n   = 1'b1;
        u_if.io0_in = 1'b0;
        #32;
        @(negedge clk); #2;
        test_reset();
        test_read_after_reset();
        test_write_then_read();
        test_illegal();
        test_abort_write();
        test_reset_mid_read();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
